pbit_gibbs_engine: RTL and testbench

- Parametrised, sequential successor to the hard-coded p-bit gate blocks.
- Holds N_PBITS stochastic bits with a programmable signed coupling matrix J and bias vector h.
- Runs Gibbs sweeps: serially computes each bit's activation, saturates it to 0..15 around OFFSET, and samples the new spin against an LFSR.
- Any gate (COPY/NOT/AND/OR/HA/FA or larger) becomes a weight load instead of a new module; sits between the config bus and the spin-readout logic.

---
 rtl/pbit_gibbs_engine_pkg.sv | 39 +++
 rtl/pbit_gibbs_engine_lfsr16.sv | 22 ++
 rtl/pbit_gibbs_engine.sv | 152 +++++++++++++++
 tb/tb_pbit_gibbs_engine.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pbit_gibbs_engine_pkg.sv
// Shared types, constants and helpers for the p-bit Gibbs engine.
package pbit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ACCUM,
    ST_SAMPLE,
    ST_DONE
  } pbit_state_e;

  localparam int ACT_MAX = 15;
  localparam int ACT_MIN = 0;

  // Galois taps for x^16+x^14+x^13+x^11+1, right-shifting form.
  localparam logic [15:0] LFSR_POLY         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_POLY) : (q >> 1);
  endfunction

  // Random nibble drawn from the freshly advanced LFSR state.
  function automatic logic [3:0] lfsr_rnd(input logic [15:0] q);
    logic [15:0] nq;
    nq = lfsr_step(q);
    return nq[3:0];
  endfunction

  // Shift the accumulator by the neutral offset and clip into 0..15.
  function automatic logic [3:0] sat_act(input int acc, input int offset);
    int a;
    a = acc + offset;
    if (a < ACT_MIN) return 4'(ACT_MIN);
    if (a > ACT_MAX) return 4'(ACT_MAX);
    return 4'(a);
  endfunction

endpackage

// File: rtl/pbit_gibbs_engine_lfsr16.sv
// 16-bit Galois LFSR; a zero seed falls back to the default seed.
module pbit_lfsr16
  import pbit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] seed_eff;

  assign seed_eff = (seed == 16'h0) ? LFSR_DEFAULT_SEED : seed;

  // Advance only when enabled so the random stream is tied to sample events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= seed_eff;
    else if (en) q <= lfsr_step(q);
  end

endmodule

// File: rtl/pbit_gibbs_engine.sv
// Sequential p-bit network: programmable J/h, serial Gibbs sweeps, LFSR sampling.
module pbit_gibbs_engine
  import pbit_pkg::*;
#(
  parameter int          N_PBITS   = 5,
  parameter int          W_WEIGHT  = 4,
  parameter int          OFFSET    = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         ADDR_W    = $clog2(N_PBITS*N_PBITS + N_PBITS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_we,
  input  logic [ADDR_W-1:0]   cfg_addr,
  input  logic [W_WEIGHT-1:0] cfg_data,
  input  logic [N_PBITS-1:0]  clamp_mask,
  input  logic [N_PBITS-1:0]  clamp_val,
  input  logic                start,
  input  logic [15:0]         n_sweeps,
  output logic                busy,
  output logic                done,
  output logic [N_PBITS-1:0]  spins,
  output logic [15:0]         sweep_count
);

  localparam int IDX_W = $clog2(N_PBITS);
  // Headroom for h plus N-1 couplings of full magnitude, plus sign.
  localparam int ACC_W = W_WEIGHT + $clog2(N_PBITS+1) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PBITS-1);

  pbit_state_e state_q, state_nx;

  logic [N_PBITS-1:0][N_PBITS-1:0][W_WEIGHT-1:0] j_mem;
  logic [N_PBITS-1:0][W_WEIGHT-1:0]              h_mem;

  logic [IDX_W-1:0]        i_q, j_q;
  logic signed [ACC_W-1:0] acc_q;
  logic [15:0]             sweep_q, nsw_q, sweep_inc;
  logic [N_PBITS-1:0]      spins_q, spins_nx, spins_clamped;
  logic                    last_bit, lfsr_en, new_spin;
  logic [15:0]             lfsr_q;
  logic [3:0]              act, rnd;
  logic signed [W_WEIGHT-1:0] j_sel, h_sel;

  assign spins       = spins_q;
  assign sweep_count = sweep_q;
  assign last_bit    = (i_q == LAST_IDX);
  assign sweep_inc   = sweep_q + 16'd1;
  assign j_sel       = j_mem[i_q][j_q];
  assign h_sel       = h_mem[i_q];
  assign spins_clamped = (spins_q & ~clamp_mask) | (clamp_val & clamp_mask);

  pbit_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (lfsr_en),
    .seed  (LFSR_SEED),
    .q     (lfsr_q)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nx;
  end

  // FSM next-state: one LOAD, N ACCUM and one SAMPLE cycle per bit.
  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_nx = (n_sweeps == 16'd0) ? ST_DONE : ST_LOAD;
      ST_LOAD:   state_nx = ST_ACCUM;
      ST_ACCUM:  if (j_q == LAST_IDX) state_nx = ST_SAMPLE;
      ST_SAMPLE: state_nx = (last_bit && sweep_inc == nsw_q) ? ST_DONE : ST_LOAD;
      ST_DONE:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // FSM outputs: busy covers the compute states only, done is the DONE cycle.
  always_comb begin
    busy    = (state_q == ST_LOAD) || (state_q == ST_ACCUM) || (state_q == ST_SAMPLE);
    done    = (state_q == ST_DONE);
    lfsr_en = (state_q == ST_SAMPLE);
  end

  // Config storage; writes land only while no run is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_mem <= '0;
      h_mem <= '0;
    end else if (cfg_we && !busy) begin
      for (int r = 0; r < N_PBITS; r++) begin
        for (int c = 0; c < N_PBITS; c++)
          if (int'(cfg_addr) == r*N_PBITS + c) j_mem[r][c] <= cfg_data;
        if (int'(cfg_addr) == N_PBITS*N_PBITS + r) h_mem[r] <= cfg_data;
      end
    end
  end

  // Activation, draw and next spin vector; clamps are re-applied on every sample.
  always_comb begin
    act = sat_act(int'(acc_q), OFFSET);
    rnd = lfsr_rnd(lfsr_q);
    if (act == 4'(ACT_MIN))      new_spin = 1'b0;
    else if (act == 4'(ACT_MAX)) new_spin = 1'b1;
    else                         new_spin = (rnd < act);
    spins_nx = spins_q;
    if (!clamp_mask[i_q]) spins_nx[i_q] = new_spin;
    spins_nx = (spins_nx & ~clamp_mask) | (clamp_val & clamp_mask);
  end

  // Datapath: bit/column counters, accumulator, spins and sweep bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      sweep_q <= '0;
      nsw_q   <= '0;
      spins_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start) begin
          nsw_q   <= n_sweeps;
          sweep_q <= '0;
          i_q     <= '0;
          spins_q <= spins_clamped;
        end
        ST_LOAD: begin
          acc_q <= ACC_W'(h_sel);
          j_q   <= '0;
        end
        ST_ACCUM: begin
          if (spins_q[j_q] && (j_q != i_q)) acc_q <= acc_q + ACC_W'(j_sel);
          j_q <= j_q + 1'b1;
        end
        ST_SAMPLE: begin
          spins_q <= spins_nx;
          if (last_bit) begin
            i_q     <= '0;
            sweep_q <= sweep_inc;
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pbit_gibbs_engine.sv
// Self-checking bench for pbit_gibbs_engine (N=5, W=4, OFFSET=8).
module tb_pbit_gibbs_engine;

  localparam int N  = 5;
  localparam int BT = N + 2;      // cycles per bit
  localparam int ST = N * BT;     // cycles per sweep

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [3:0]  cfg_data;
  logic [4:0]  clamp_mask, clamp_val;
  logic        start;
  logic [15:0] n_sweeps;
  logic        busy, done;
  logic [4:0]  spins;
  logic [15:0] sweep_count;

  pbit_gibbs_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .clamp_mask  (clamp_mask),
    .clamp_val   (clamp_val),
    .start       (start),
    .n_sweeps    (n_sweeps),
    .busy        (busy),
    .done        (done),
    .spins       (spins),
    .sweep_count (sweep_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state of the network.
  int          m_j [N][N];
  int          m_h [N];
  logic [4:0]  m_spins;
  logic [15:0] m_lfsr;
  logic [4:0]  exp_q[$];

  typedef struct {
    string      name;
    logic [4:0] a0; logic [3:0] d0;
    logic [4:0] a1; logic [3:0] d1;
    logic [4:0] a2; logic [3:0] d2;
    logic [4:0] mask, val;
    int         nsw;
    int         bidx;   // -1: rely on the reference model only
    logic       exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] q);
    logic [15:0] s;
    s = q >> 1;
    if (q[0]) s = s ^ 16'hB400;
    return s;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < N; r++) begin
      m_h[r] = 0;
      for (int c = 0; c < N; c++) m_j[r][c] = 0;
    end
    m_spins = '0;
    m_lfsr  = 16'hACE1;
    exp_q.delete();
  endtask

  // Reference Gibbs run: pushes the expected spin vector after each sweep.
  task automatic model_run(input int n, input logic [4:0] m, input logic [4:0] v);
    int acc, a;
    logic [3:0] rnd;
    logic ns;
    m_spins = (m_spins & ~m) | (v & m);
    for (int s = 0; s < n; s++) begin
      for (int i = 0; i < N; i++) begin
        acc = m_h[i];
        for (int j = 0; j < N; j++)
          if (j != i && m_spins[j]) acc += m_j[i][j];
        a = 8 + acc;
        if (a < 0) a = 0;
        if (a > 15) a = 15;
        m_lfsr = ref_step(m_lfsr);
        rnd = m_lfsr[3:0];
        if (a == 0)       ns = 1'b0;
        else if (a == 15) ns = 1'b1;
        else              ns = (int'(rnd) < a);
        if (!m[i]) m_spins[i] = ns;
        m_spins = (m_spins & ~m) | (v & m);
      end
      exp_q.push_back(m_spins);
    end
  endtask

  task automatic wr(input logic [4:0] addr, input logic [3:0] data);
    int a, d;
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
    @(negedge clk);
    cfg_we = 1'b0;
    a = int'(addr);
    d = $signed(data);
    if (a < N*N)        m_j[a/N][a%N] = d;
    else if (a < N*N+N) m_h[a-N*N]    = d;
  endtask

  task automatic clear_weights();
    for (int a = 0; a < N*N+N; a++) wr(5'(a), 4'h0);
  endtask

  // One run: checks busy length, done cycle, per-sweep spins and sweep_count.
  // poke injects a config write and a start pulse while busy.
  task automatic run(input string tag, input int n, input logic [4:0] m,
                     input logic [4:0] v, input bit poke);
    int t, bcnt, early;
    logic [4:0] e;
    @(negedge clk);
    clamp_mask = m; clamp_val = v;
    model_run(n, m, v);
    n_sweeps = 16'(n);
    start = 1'b1;
    t = n * ST;
    bcnt = 0; early = 0;
    @(posedge clk);                       // start accepted: end of cycle 0
    for (int k = 1; k <= t + 1; k++) begin
      #1;
      if (k == 1) start = 1'b0;
      if (poke && k == 3) begin
        cfg_we = 1'b1; cfg_addr = 5'd5; cfg_data = 4'h8; start = 1'b1;
      end
      if (poke && k == 4) begin
        cfg_we = 1'b0; start = 1'b0;
      end
      if (k <= t) begin
        if (busy) bcnt++;
        if (done) early++;
      end
      if (k > 1 && (k - 1) % ST == 0) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL %s scoreboard: queue empty at cycle %0d", tag, k);
        end else begin
          e = exp_q.pop_front();
          chk({tag, " sweep_spins"}, 32'(spins), 32'(e));
        end
      end
      if (k == t + 1) chk({tag, " done_cycle busy,done"}, {30'd0, busy, done}, 32'b01);
      @(posedge clk);
    end
    #1;
    chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
    if (n > 0) begin
      chk({tag, " busy_cycles"}, 32'(bcnt), 32'(t));
      chk({tag, " early_done"}, 32'(early), 32'd0);
    end
    chk({tag, " sweep_count"}, 32'(sweep_count), 32'(n));
    chk({tag, " final_spins"}, 32'(spins), 32'(m_spins));
  endtask

  initial begin
    vecs[0] = '{"copy_one",  5'd5,  4'h7, 5'd26, 4'h1, 5'd0,  4'h0, 5'b00001, 5'b00001, 1, 1, 1'b1};
    vecs[1] = '{"copy_zero", 5'd5,  4'h7, 5'd26, 4'h8, 5'd0,  4'h0, 5'b00001, 5'b00000, 1, 1, 1'b0};
    vecs[2] = '{"not_gate",  5'd5,  4'h8, 5'd26, 4'h0, 5'd0,  4'h0, 5'b00001, 5'b00001, 1, 1, 1'b0};
    vecs[3] = '{"and_11",    5'd10, 4'h7, 5'd11, 4'h7, 5'd27, 4'h9, 5'b00011, 5'b00011, 1, 2, 1'b1};
    vecs[4] = '{"and_01",    5'd10, 4'h7, 5'd11, 4'h7, 5'd27, 4'h9, 5'b00011, 5'b00001, 2, -1, 1'b0};
    vecs[5] = '{"and_00",    5'd10, 4'h7, 5'd11, 4'h7, 5'd27, 4'h9, 5'b00011, 5'b00000, 2, -1, 1'b0};

    rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    clamp_mask = '0; clamp_val = '0; start = 1'b0; n_sweeps = '0;
    model_reset();
    #12;
    chk("reset spins", 32'(spins), 32'd0);
    chk("reset sweep_count", 32'(sweep_count), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Timing with zero weights: 105 busy cycles, done at cycle 106.
    run("timing", 3, 5'b00000, 5'b00000, 1'b0);

    // n_sweeps = 0: immediate done, only the clamp touches spins.
    run("zero_sweeps", 0, 5'b00101, 5'b00100, 1'b0);

    // Reset in the middle of the second sweep's ACCUM phase.
    @(negedge clk);
    clamp_mask = 5'b11111; clamp_val = 5'b11111; n_sweeps = 16'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    chk("midrun busy", 32'(busy), 32'd1);
    chk("midrun sweep_count", 32'(sweep_count), 32'd1);
    rst_n = 1'b0;
    #2;
    chk("abort spins", 32'(spins), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort sweep_count", 32'(sweep_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("abort no done", 32'(done), 32'd0);
    model_reset();
    clamp_mask = '0; clamp_val = '0;
    @(negedge clk); rst_n = 1'b1;

    // LFSR stream after reset: act=8 everywhere, 100 sweeps.
    run("lfsr", 100, 5'b00000, 5'b00000, 1'b0);

    // Gate vectors.
    for (int v = 0; v < 6; v++) begin
      clear_weights();
      wr(vecs[v].a0, vecs[v].d0);
      wr(vecs[v].a1, vecs[v].d1);
      wr(vecs[v].a2, vecs[v].d2);
      run(vecs[v].name, vecs[v].nsw, vecs[v].mask, vecs[v].val, 1'b0);
      if (vecs[v].bidx >= 0)
        chk({vecs[v].name, " gate_out"}, 32'(spins[vecs[v].bidx]), 32'(vecs[v].exp));
    end

    // Config write and start while busy are ignored; readback run proves J kept.
    clear_weights();
    wr(5'd5, 4'h7);
    wr(5'd26, 4'h1);
    run("busy_guard", 1, 5'b00001, 5'b00001, 1'b1);
    run("busy_readback", 1, 5'b00001, 5'b00001, 1'b0);
    chk("busy_readback copy", 32'(spins[1]), 32'd1);

    // Out-of-range writes must not land anywhere: all h=+7 forces every spin high.
    clear_weights();
    for (int i = 0; i < N; i++) wr(5'(N*N + i), 4'h7);
    wr(5'd30, 4'h8);
    wr(5'd31, 4'h8);
    run("oor", 1, 5'b00000, 5'b00000, 1'b0);
    chk("oor spins", 32'(spins), 32'h1F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time bound so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
